// File: rtl/fpu_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 mantissa multiplier.
// Optional build macro: FPU_MUL_ZERO_SKIP_EN (see fpu_mul_iter.sv).
package fpu_mul_pkg;

    // Controller states of the multiplier
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 iteration count: operand width rounded up to even, halved
    function automatic int iters(input int width);
        return (width + 1) / 2;
    endfunction

    localparam int DEF_WIDTH = 27;
    // Edges from accept to the done edge for the default width
    localparam int LATENCY   = iters(DEF_WIDTH) + 1;

endpackage

// File: rtl/fpu_mul_pp_sel.sv
// Radix-4 partial-product selector: picks 0, a, 2a or 3a from two multiplier bits.
module fpu_mul_pp_sel #(
    parameter int WIDTH = 27
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH+1:0] a3,
    output logic [WIDTH+1:0] pp
);

    // Pure multiplexer; 3a is precomputed so no adder sits on this path
    always_comb begin
        pp = '0;
        case (sel)
            2'd0: pp = '0;
            2'd1: pp = (WIDTH+2)'(a);
            2'd2: pp = (WIDTH+2)'({a, 1'b0});
            2'd3: pp = a3;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/fpu_mul_iter.sv
// Multi-cycle unsigned mantissa multiplier, radix-4 shift-add, start/done handshake.
// Optional build macro: FPU_MUL_ZERO_SKIP_EN -- a zero operand finishes one edge after accept.
module fpu_mul_iter
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int WP    = WIDTH + (WIDTH % 2);
    localparam int AW    = 2 * WP;
    localparam int ITERS = iters(WIDTH);
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH+1:0]     r_a3;
    logic [WP-1:0]        r_b;
    logic [AW-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_ready;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH+1:0]     w_a3_in;
    logic [WIDTH+1:0]     w_pp;
    logic [AW-1:0]        w_pp_shift;
    logic [CW:0]          w_shamt;
    logic                 w_finish;

    assign w_a3_in    = (WIDTH+2)'(a) + ((WIDTH+2)'(a) << 1);
    assign w_shamt    = {r_cnt, 1'b0};
    assign w_pp_shift = AW'(w_pp) << w_shamt;

    fpu_mul_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .sel (r_b[1:0]),
        .a   (r_a),
        .a3  (r_a3),
        .pp  (w_pp)
    );

`ifdef FPU_MUL_ZERO_SKIP_EN
    logic r_zero;

    // Remember whether either operand was zero so the iterations can be skipped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_zero <= (a == '0) || (b == '0);
        end
    end

    assign w_finish = (r_cnt == LAST_CNT) || r_zero;
`else
    assign w_finish = (r_cnt == LAST_CNT);
`endif

    // Controller, operand/accumulator datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_a3      <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_a3    <= w_a3_in;
                        r_b     <= WP'(b);   // pad bits forced to zero
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (w_finish) begin
                        // Exact product always fits in the low 2*WIDTH bits
                        r_product <= r_acc[2*WIDTH-1:0];
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_acc <= r_acc + w_pp_shift;
                        r_b   <= r_b >> 2;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_fpu_mul_iter.sv
// Self-checking bench for fpu_mul_iter: directed corner cases plus random back-to-back operations.
module tb_fpu_mul_iter;

    localparam int W       = 27;
    localparam int EXP_LAT = (W + 1) / 2 + 1;   // iterations plus the finishing edge

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            ready;
    logic            done;
    logic [2*W-1:0]  product;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int done_exp  = 0;

    fpu_mul_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Count every done pulse (one-cycle pulses are seen exactly once at negedge)
    always @(negedge clk) if (done) done_seen++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic product and the latency the op should take
    function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return 64'(x) * 64'(y);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef FPU_MUL_ZERO_SKIP_EN
        if (x == '0 || y == '0) return 1;
`endif
        return EXP_LAT;
    endfunction

    // Waits for ready, launches one op, returns edges-to-done and the product
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                          input logic scramble, output int lat, output logic [63:0] prod);
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
        a = ta; b = tb_in; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            a = W'($urandom); b = W'($urandom);
        end
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
        prod = 64'(product);
        done_exp++;
        $display("op a=0x%07h b=0x%07h -> product=0x%014h latency=%0d", ta, tb_in, product, lat);
    endtask

    initial begin
        int lat;
        logic [63:0] p;
        logic [W-1:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // T1: small product, latency, ready timing, hold
        run_op(27'd3, 27'd5, 1'b0, lat, p);
        chk("t1_lat", 64'(lat), 64'(EXP_LAT));
        chk("t1_prod", p, ref_mul(27'd3, 27'd5));
        chk("t1_ready_in_done", 64'(ready), 64'd0);
        @(posedge clk); #1;
        chk("t1_ready_after", 64'(ready), 64'd1);
        chk("t1_done_pulse", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_hold", 64'(product), 64'd15);

        // T2: full-width carry check
        run_op(27'h7FFFFFF, 27'h7FFFFFF, 1'b0, lat, p);
        chk("t2_prod", p, 64'h3FFFFFF0000001);
        chk("t2_lat", 64'(lat), 64'(EXP_LAT));

        // T3: zero operand
        run_op(27'd0, 27'h1234567, 1'b0, lat, p);
        chk("t3_prod", p, 64'd0);
        chk("t3_lat", 64'(lat), 64'(ref_lat(27'd0, 27'h1234567)));

        // T4: start pulse during CALC must be ignored
        @(posedge clk); #1;
        a = 27'd2; b = 27'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a = 27'd7; b = 27'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        done_exp++;
        chk("t4_prod", 64'(product), 64'd8);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_no_second_done", 64'(done_seen), 64'(done_exp));
        $display("op a=0x%07h b=0x%07h -> product=0x%014h (stray start ignored)", 27'd2, 27'd4, product);

        // T5: asynchronous reset mid-operation, with start raised alongside it
        a = 27'd5; b = 27'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1; start = 1'b1;
        #1;
        chk("t5_ready", 64'(ready), 64'd1);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_product", 64'(product), 64'd0);
        @(negedge clk); start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle_after", 64'(ready), 64'd1);
        $display("reset mid-op: ready=%0b done=%0b product=0x%0h", ready, done, product);
        run_op(27'd6, 27'd7, 1'b0, lat, p);
        chk("t5_prod", p, 64'd42);
        chk("t5_lat", 64'(lat), 64'(EXP_LAT));

        // T6: random back-to-back ops, inputs scrambled while busy
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 17 == 3) ra = '0;
            if (i % 23 == 5) rb = '0;
            run_op(ra, rb, 1'b1, lat, p);
            chk("t6_prod", p, ref_mul(ra, rb));
            chk("t6_lat", 64'(lat), 64'(ref_lat(ra, rb)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 64'(done_seen), 64'(done_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
